sys_pio_out: RTL



---
 rtl/sys_pio_out_pkg.sv | 25 ++
 rtl/sys_pio_pulse_timer.sv | 76 +++++++
 rtl/sys_pio_out.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sys_pio_out_pkg.sv
// Shared definitions for the output PIO: register map, STATUS bit
// positions and the pulse-timer state encoding.
package sys_pio_out_pkg;

  // Word addresses of the register map
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_STATUS    = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE     = 3'd6;
  localparam logic [2:0] ADDR_RSVD      = 3'd7;

  // STATUS register bit positions
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  // Pulse timer states
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/sys_pio_pulse_timer.sv
// One-shot pulse timer. A start loads the counter with the programmed
// length (0 is treated as 1) and the timer runs until the counter has
// been seen at 1, at which point expire is strobed for one cycle and the
// timer returns to idle. A start while running reloads the counter and
// suppresses that cycle's expiry, so a retrigger never reports done.
module sys_pio_pulse_timer
  import sys_pio_out_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             expire,
  output pulse_state_e     state_o
);

  pulse_state_e     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] load_val;

  // Length actually loaded: a zero length still produces a one-clock pulse
  always_comb begin
    load_val = len;
    if (len == '0) begin
      load_val = CNT_W'(1);
    end
  end

  // Next-state and counter logic; expire is a strobe for the expiry edge
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    expire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = load_val;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (start) begin
          count_d = load_val;
        end else if (count_q == CNT_W'(1)) begin
          expire  = 1'b1;
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign busy    = (state_q == ST_ACTIVE);
  assign state_o = state_q;

endmodule

// File: rtl/sys_pio_out.sv
// Avalon-MM output PIO. out_port is driven straight from the data
// register, which the CPU can write whole, set/clear bitwise, or pulse
// for a programmed number of clocks. Pulse completion sets a sticky done
// flag that raises irq when unmasked.
//
// Bus handshake: there is no waitrequest; a write is accepted on every
// edge where chipselect is high and write_n is low, and readdata is
// re-registered every cycle from the addressed register, so a read
// issued on one edge is valid after the next edge.
module sys_pio_out
  import sys_pio_out_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                CNT_W       = 16,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  logic              wr_en;
  logic [DATA_W-1:0] wr_bits;
  logic              pulse_wr;

  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] pulse_bits_q, pulse_bits_d;
  logic              done_q, done_d;
  logic              mask_q, mask_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [31:0]       readdata_q, readdata_d;

  logic              tmr_busy;
  logic              tmr_expire;
  pulse_state_e      tmr_state;

  // Bus decode
  always_comb begin
    wr_en    = chipselect & ~write_n;
    wr_bits  = writedata[DATA_W-1:0];
    pulse_wr = wr_en && (address == ADDR_PULSE);
  end

  sys_pio_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (pulse_wr),
    .len     (len_q),
    .busy    (tmr_busy),
    .expire  (tmr_expire),
    .state_o (tmr_state)
  );

  // Register updates: the expiry clear lands first, then the bus write,
  // and finally the done set so it beats a same-edge STATUS clear
  always_comb begin
    out_d        = out_q;
    pulse_bits_d = pulse_bits_q;
    done_d       = done_q;
    mask_d       = mask_q;
    len_d        = len_q;

    if (tmr_expire) begin
      out_d        = out_d & ~pulse_bits_q;
      pulse_bits_d = '0;
    end

    if (wr_en) begin
      case (address)
        ADDR_DATA:      out_d = wr_bits;
        ADDR_STATUS: begin
          if (writedata[STATUS_DONE_BIT]) begin
            done_d = 1'b0;
          end
        end
        ADDR_IRQ_MASK:  mask_d = writedata[0];
        ADDR_PULSE_LEN: len_d  = writedata[CNT_W-1:0];
        ADDR_OUTSET:    out_d  = out_d | wr_bits;
        ADDR_OUTCLEAR:  out_d  = out_d & ~wr_bits;
        ADDR_PULSE: begin
          out_d = out_d | wr_bits;
          // A fresh pulse replaces the bit set; a retrigger extends it
          if (tmr_state == ST_IDLE) begin
            pulse_bits_d = wr_bits;
          end else begin
            pulse_bits_d = pulse_bits_d | wr_bits;
          end
        end
        default: ;
      endcase
    end

    if (tmr_expire) begin
      done_d = 1'b1;
    end
  end

  // Read mux, registered every cycle irrespective of any read strobe
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:      readdata_d[DATA_W-1:0] = out_q;
      ADDR_STATUS: begin
        readdata_d[STATUS_BUSY_BIT] = tmr_busy;
        readdata_d[STATUS_DONE_BIT] = done_q;
      end
      ADDR_IRQ_MASK:  readdata_d[0] = mask_q;
      ADDR_PULSE_LEN: readdata_d[CNT_W-1:0] = len_q;
      ADDR_PULSE:     readdata_d[DATA_W-1:0] = pulse_bits_q;
      ADDR_OUTSET, ADDR_OUTCLEAR, ADDR_RSVD: readdata_d = '0;
      default:        readdata_d = '0;
    endcase
  end

  // Architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= RESET_VALUE;
      pulse_bits_q <= '0;
      done_q       <= 1'b0;
      mask_q       <= 1'b0;
      len_q        <= CNT_W'(1);
      readdata_q   <= '0;
    end else begin
      out_q        <= out_d;
      pulse_bits_q <= pulse_bits_d;
      done_q       <= done_d;
      mask_q       <= mask_d;
      len_q        <= len_d;
      readdata_q   <= readdata_d;
    end
  end

  assign out_port = out_q;
  assign readdata = readdata_q;
  assign irq      = done_q & mask_q;

endmodule
